// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: sequencer between the keypad scanner and the calculator
// arithmetic unit. It turns the key-read level into single key events,
// assembles two BCD operands and an operator, issues one valid/ready request,
// and latches the result for display.
// Build option KEY_DEBOUNCE_EN: when defined, a key event needs DEBOUNCE_CYCLES
// consecutive high samples and a release needs DEBOUNCE_CYCLES consecutive low
// samples. When undefined, both need a single sample.
module calc_entry_ctrl #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                KEY_READ,
  input  logic [3:0]          BCD_KEY,
  output logic                ENABLE_KEYB,
  output logic [4*DIGITS-1:0] OP_A,
  output logic [4*DIGITS-1:0] OP_B,
  output logic [1:0]          OPCODE,
  output logic                CALC_VALID,
  input  logic                CALC_READY,
  input  logic [4*DIGITS-1:0] RESULT,
  input  logic                RESULT_VALID,
  output logic [4*DIGITS-1:0] DISP
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
`ifdef KEY_DEBOUNCE_EN
  localparam int DB_N = DEBOUNCE_CYCLES;
`else
  localparam int DB_N = 1;
`endif
  localparam logic [DW-1:0] DB_LAST  = DW'(DB_N - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

  typedef enum logic [2:0] {
    S_A,
    S_B,
    S_REQ,
    S_WAIT,
    S_RES
  } state_t;

  // Debouncer state: released_q is set once the key has been seen released
  // long enough; db_cnt_q counts consecutive samples at the awaited level.
  logic          released_q, released_d;
  logic [DW-1:0] db_cnt_q,   db_cnt_d;
  logic          key_ev_q,   key_ev_d;
  logic [3:0]    key_code_q, key_code_d;

  state_t        state_q,    state_d;
  logic [W-1:0]  op_a_q,     op_a_d;
  logic [W-1:0]  op_b_q,     op_b_d;
  logic [1:0]    opcode_q,   opcode_d;
  logic [W-1:0]  disp_q,     disp_d;
  logic          calc_valid_q, calc_valid_d;
  logic          en_keyb_q,  en_keyb_d;
  logic [CW-1:0] a_cnt_q,    a_cnt_d;
  logic [CW-1:0] b_cnt_q,    b_cnt_d;

  logic          is_digit, is_op, is_eq, is_clr;
  logic [W-1:0]  digit_ext;
  logic [1:0]    key_opcode;

  // Debouncer next state: count stable samples, pulse once per press.
  always_comb begin
    released_d = released_q;
    db_cnt_d   = db_cnt_q;
    key_ev_d   = 1'b0;
    key_code_d = key_code_q;
    if (released_q) begin
      if (KEY_READ) begin
        if (db_cnt_q == DB_LAST) begin
          key_ev_d   = 1'b1;
          key_code_d = BCD_KEY;
          released_d = 1'b0;
          db_cnt_d   = '0;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end else begin
        db_cnt_d = '0;
      end
    end else begin
      if (!KEY_READ) begin
        if (db_cnt_q == DB_LAST) begin
          released_d = 1'b1;
          db_cnt_d   = '0;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end else begin
        db_cnt_d = '0;
      end
    end
  end

  // Debouncer registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      released_q <= 1'b0;
      db_cnt_q   <= '0;
      key_ev_q   <= 1'b0;
      key_code_q <= '0;
    end else begin
      released_q <= released_d;
      db_cnt_q   <= db_cnt_d;
      key_ev_q   <= key_ev_d;
      key_code_q <= key_code_d;
    end
  end

  assign is_digit   = (key_code_q < 4'd10);
  assign is_op      = (key_code_q >= 4'd10) && (key_code_q <= 4'd13);
  assign is_eq      = (key_code_q == 4'd14);
  assign is_clr     = (key_code_q == 4'd15);
  assign digit_ext  = W'(key_code_q);
  assign key_opcode = key_code_q[1:0] - 2'd2;

  // Entry FSM: next state and all registered outputs.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    opcode_d     = opcode_q;
    disp_d       = disp_q;
    calc_valid_d = calc_valid_q;
    en_keyb_d    = en_keyb_q;
    a_cnt_d      = a_cnt_q;
    b_cnt_d      = b_cnt_q;
    case (state_q)
      S_A: begin
        if (key_ev_q) begin
          if (is_clr) begin
            op_a_d   = '0;
            op_b_d   = '0;
            opcode_d = '0;
            disp_d   = '0;
            a_cnt_d  = '0;
            b_cnt_d  = '0;
          end else if (is_digit) begin
            if (a_cnt_q != CNT_FULL) begin
              op_a_d  = (op_a_q << 4) | digit_ext;
              a_cnt_d = a_cnt_q + CW'(1);
              disp_d  = op_a_d;
            end
          end else if (is_op) begin
            opcode_d = key_opcode;
            op_b_d   = '0;
            b_cnt_d  = '0;
            disp_d   = '0;
            state_d  = S_B;
          end
        end
      end
      S_B: begin
        if (key_ev_q) begin
          if (is_clr) begin
            op_a_d   = '0;
            op_b_d   = '0;
            opcode_d = '0;
            disp_d   = '0;
            a_cnt_d  = '0;
            b_cnt_d  = '0;
            state_d  = S_A;
          end else if (is_digit) begin
            if (b_cnt_q != CNT_FULL) begin
              op_b_d  = (op_b_q << 4) | digit_ext;
              b_cnt_d = b_cnt_q + CW'(1);
              disp_d  = op_b_d;
            end
          end else if (is_op) begin
            if (b_cnt_q == '0) begin
              opcode_d = key_opcode;
            end
          end else if (is_eq) begin
            if (b_cnt_q != '0) begin
              calc_valid_d = 1'b1;
              en_keyb_d    = 1'b0;
              state_d      = S_REQ;
            end
          end
        end
      end
      S_REQ: begin
        if (CALC_READY) begin
          calc_valid_d = 1'b0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (RESULT_VALID) begin
          disp_d    = RESULT;
          op_a_d    = RESULT;
          en_keyb_d = 1'b1;
          state_d   = S_RES;
        end
      end
      S_RES: begin
        if (key_ev_q) begin
          if (is_clr) begin
            op_a_d   = '0;
            op_b_d   = '0;
            opcode_d = '0;
            disp_d   = '0;
            a_cnt_d  = '0;
            b_cnt_d  = '0;
            state_d  = S_A;
          end else if (is_digit) begin
            op_a_d  = digit_ext;
            a_cnt_d = CW'(1);
            disp_d  = digit_ext;
            state_d = S_A;
          end else if (is_op) begin
            opcode_d = key_opcode;
            op_b_d   = '0;
            b_cnt_d  = '0;
            disp_d   = '0;
            state_d  = S_B;
          end
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
  end

  // Entry FSM registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_A;
      op_a_q       <= '0;
      op_b_q       <= '0;
      opcode_q     <= '0;
      disp_q       <= '0;
      calc_valid_q <= 1'b0;
      en_keyb_q    <= 1'b1;
      a_cnt_q      <= '0;
      b_cnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      opcode_q     <= opcode_d;
      disp_q       <= disp_d;
      calc_valid_q <= calc_valid_d;
      en_keyb_q    <= en_keyb_d;
      a_cnt_q      <= a_cnt_d;
      b_cnt_q      <= b_cnt_d;
    end
  end

  assign ENABLE_KEYB = en_keyb_q;
  assign OP_A        = op_a_q;
  assign OP_B        = op_b_q;
  assign OPCODE      = opcode_q;
  assign CALC_VALID  = calc_valid_q;
  assign DISP        = disp_q;

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Sequencer between the keypad scanner and the calculator arithmetic unit. Turns the scanner's level-type key-read strobe and 4-bit key code into single key events, with optional debouncing. Assembles two BCD operands and an operator from those events, issues one calculation request over a valid/ready handshake, and latches the result for display. It also gates the keypad through ENABLE_KEYB while a calculation is in flight.

## Interface
- DIGITS, 4: BCD digits per operand; bus width W = 4*DIGITS.
- DEBOUNCE_CYCLES, 4: consecutive stable samples required by the debouncer; ≥1.

- CLK  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- KEY_READ  in  1  scanner key-pressed level; high while a key is held.
- BCD_KEY  in  4  key code, bit 3 = MSB; valid while KEY_READ high.
- ENABLE_KEYB  out  1  keypad enable.
- OP_A  out  W  operand A, BCD, most-significant digit in top nibble.
- OP_B  out  W  operand B, BCD.
- OPCODE  out  2  operator: 0 = +, 1 = −, 2 = ×, 3 = ÷.
- CALC_VALID  out  1  calculation request.
- CALC_READY  in  1  arithmetic unit accepts request.
- RESULT  in  W  BCD result.
- RESULT_VALID  in  1  one-cycle result strobe.
- DISP  out  W  BCD value for the display driver.

## Operation
- Key map:
  - 0–9: digit.
  - 10–13: operator; OPCODE = code − 10.
  - 14: '='.
  - 15: 'C', clear all.
- Debouncer:
  - Produces internal one-cycle pulse KEY_EV and latches BCD_KEY with it.
  - After an event, no further event until KEY_READ has been low for DEBOUNCE_CYCLES consecutive samples.
  - Runs in every state.
- Digit entry: shift left one nibble, insert the digit. When DIGITS digits are already entered, the digit is dropped.
- States and transitions:
  - S_A, entering A:
    - digit → into A.
    - operator → latch OPCODE, B := 0, go S_B.
    - '=' ignored.
  - S_B, entering B:
    - digit → into B.
    - operator with no B digit yet → replace OPCODE.
    - operator after a B digit → ignored.
    - '=' with at least one B digit → S_REQ.
    - '=' with no B digit → ignored.
  - S_REQ: CALC_VALID = 1, with OP_A/OP_B/OPCODE frozen. CALC_READY sampled high → S_WAIT.
  - S_WAIT:
    - RESULT_VALID → DISP := RESULT, A := RESULT, go S_RES.
    - RESULT_VALID outside S_WAIT is ignored.
  - S_RES:
    - digit → A := digit, digit count = 1, go S_A.
    - operator → keep A = result, latch OPCODE, B := 0, go S_B.
    - '=' ignored.
- 'C' in S_A, S_B or S_RES: A, B, OPCODE, DISP := 0; go S_A.
- ENABLE_KEYB = 1 in S_A, S_B and S_RES; 0 in S_REQ and S_WAIT. KEY_EV in S_REQ/S_WAIT is discarded.
- DISP source by state:
  - S_A: A.
  - S_B: B (0 before the first B digit).
  - S_REQ, S_WAIT: B held.
  - S_RES: result.
- All outputs are registered.

## Timing
- Reset values: state S_A, ENABLE_KEYB = 1; OP_A, OP_B, OPCODE, DISP, CALC_VALID = 0; debouncer cleared.
- Reset asserted mid-operation (including S_REQ/S_WAIT) aborts immediately; a later RESULT_VALID is ignored.
- Key latency: KEY_READ first sampled high at edge 1 → KEY_EV high after edge DEBOUNCE_CYCLES → DISP/OP/state update at edge DEBOUNCE_CYCLES+1.
- '=' event: CALC_VALID and ENABLE_KEYB = 0 are asserted at the same update edge.
- Handshake:
  - CALC_VALID holds until an edge samples CALC_READY = 1, and deasserts at that edge.
  - CALC_READY high on the same edge CALC_VALID rises is not a transfer.
  - In S_REQ, RESULT_VALID coincident with CALC_READY is ignored.
- Result: RESULT_VALID sampled in S_WAIT → DISP and ENABLE_KEYB = 1 at that edge.
- A key held across S_REQ/S_WAIT → S_RES generates no event until it is released and pressed again.

## Configuration
- KEY_DEBOUNCE_EN defined: debouncer as specified, using DEBOUNCE_CYCLES.
- Not defined:
  - KEY_EV fires on the first high sample following a low sample, i.e. DEBOUNCE_CYCLES behaves as 1.
  - Release needs one low sample.
  - DEBOUNCE_CYCLES is unused.

## Test plan
- DEBOUNCE_CYCLES=4, keys 1, 2, +, 3, = → OP_A=0x0012, OP_B=0x0003, OPCODE=0. CALC_VALID held 3 cycles until CALC_READY. RESULT=0x0015 strobed → DISP=0x0015, ENABLE_KEYB=1.
- Key 7 with KEY_READ high 3, low 1, high 5 cycles → with KEY_DEBOUNCE_EN: DISP=0x0007 (single event); without: DISP=0x0077.
- Keys 1 through 5 in S_A → DISP=0x1234; the 5 is dropped.
- After result 0x0015: keys ×, 2, = → OP_A=0x0015, OPCODE=2, OP_B=0x0002. Separate run: after result, key 9 → DISP=0x0009, state S_A.
- Keys 4, +, −, 6, = → OPCODE=1. Key held during S_WAIT → no event, ENABLE_KEYB=0 throughout.
- RESET_N low for 1 cycle during S_WAIT → all outputs reset values immediately. Subsequent RESULT_VALID → DISP stays 0.
